// File: rtl/stopwatch_10ms_bcd_if.sv
// Control, tick and display bundle between a stopwatch_10ms_bcd and its driver.
// The master drives the tick input and the control pulses. The slave is the stopwatch.
interface stopwatch_10ms_bcd_if;
    logic        tick_q;
    logic        start_stop;
    logic        lap;
    logic        clear;
    logic        delay_en;
    logic [23:0] digits;
    logic        running;
    logic        lap_active;

    modport master (
        output tick_q, start_stop, lap, clear,
        input  delay_en, digits, running, lap_active
    );

    modport slave (
        input  tick_q, start_stop, lap, clear,
        output delay_en, digits, running, lap_active
    );
endinterface

// File: rtl/stopwatch_10ms_bcd.sv
// BCD mm:ss.cc stopwatch that counts edges of the upstream 10 ms square wave.
// It provides start/stop, lap-freeze and clear control.
// Optional: define STOPWATCH_SATURATE_EN to hold at MAX_MIN:59.99 instead of wrapping.
module stopwatch_10ms_bcd #(
    parameter int unsigned MAX_MIN = 59,
    parameter int unsigned GUARD   = 2
) (
    input  logic                CLOCK_50,
    input  logic                aclr,
    stopwatch_10ms_bcd_if.slave sw
);

    localparam int unsigned GW = (GUARD == 0) ? 1 : $clog2(GUARD + 1);
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD);
    localparam logic [3:0]  MAX_T    = 4'(MAX_MIN / 10);
    localparam logic [3:0]  MAX_U    = 4'(MAX_MIN % 10);
    localparam logic [23:0] MAX_TIME = {MAX_T, MAX_U, 4'd5, 4'd9, 4'd9, 4'd9};

`ifdef STOPWATCH_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RUN       = 3'd1;
    localparam logic [2:0] S_RUN_LAP   = 3'd2;
    localparam logic [2:0] S_PAUSE     = 3'd3;
    localparam logic [2:0] S_PAUSE_LAP = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [23:0]   time_q, time_d;
    logic [23:0]   lap_q, lap_d;
    logic [GW-1:0] guard_q, guard_d;
    logic          tick_dly_q;
    logic [23:0]   digits_q, digits_d;
    logic          delay_en_q, delay_en_d;
    logic          running_q, running_d;
    logic          lap_active_q, lap_active_d;

    logic [23:0]   time_inc;
    logic          tick;
    logic          at_max;
    logic          count_en;

    // One tick per edge of the upstream square wave, rising or falling.
    assign tick   = sw.tick_q ^ tick_dly_q;
    assign at_max = (time_q == MAX_TIME);

    // BCD increment with the carry chain cs -> s -> min.
    // The minutes wrap to 00 after MAX_MIN.
    always_comb begin
        time_inc = time_q;
        if (time_q[3:0] != 4'd9) begin
            time_inc[3:0] = time_q[3:0] + 4'd1;
        end else begin
            time_inc[3:0] = 4'd0;
            if (time_q[7:4] != 4'd9) begin
                time_inc[7:4] = time_q[7:4] + 4'd1;
            end else begin
                time_inc[7:4] = 4'd0;
                if (time_q[11:8] != 4'd9) begin
                    time_inc[11:8] = time_q[11:8] + 4'd1;
                end else begin
                    time_inc[11:8] = 4'd0;
                    if (time_q[15:12] != 4'd5) begin
                        time_inc[15:12] = time_q[15:12] + 4'd1;
                    end else begin
                        time_inc[15:12] = 4'd0;
                        if ((time_q[23:20] == MAX_T) && (time_q[19:16] == MAX_U)) begin
                            time_inc[23:16] = 8'd0;
                        end else if (time_q[19:16] != 4'd9) begin
                            time_inc[19:16] = time_q[19:16] + 4'd1;
                        end else begin
                            time_inc[19:16] = 4'd0;
                            time_inc[23:20] = time_q[23:20] + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Next-state, time, lap latch, guard and registered-output logic.
    // The priority is clear, then start_stop, then lap.
    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        lap_d        = lap_q;
        guard_d      = (guard_q != '0) ? (guard_q - GW'(1)) : guard_q;
        digits_d     = time_q;
        running_d    = 1'b0;
        lap_active_d = 1'b0;
        delay_en_d   = 1'b0;

        count_en = tick && (guard_q == '0) && !(SAT_EN && at_max)
                   && ((state_q == S_RUN) || (state_q == S_RUN_LAP));
        if (count_en) begin
            time_d = time_inc;
        end

        if (sw.clear) begin
            state_d = S_IDLE;
            time_d  = '0;
            lap_d   = '0;
            guard_d = '0;
        end else if (sw.start_stop) begin
            case (state_q)
                S_IDLE:      begin state_d = S_RUN; guard_d = GUARD_LD; end
                S_RUN:       state_d = S_PAUSE;
                S_RUN_LAP:   state_d = S_PAUSE_LAP;
                S_PAUSE:     begin state_d = S_RUN; guard_d = GUARD_LD; end
                S_PAUSE_LAP: state_d = S_RUN_LAP;
                default:     state_d = S_IDLE;
            endcase
        end else if (sw.lap) begin
            case (state_q)
                S_RUN:       begin state_d = S_RUN_LAP; lap_d = time_q; end
                S_RUN_LAP:   state_d = S_RUN;
                S_PAUSE_LAP: state_d = S_PAUSE;
                default:     state_d = state_q;
            endcase
        end

        running_d    = (state_d == S_RUN) || (state_d == S_RUN_LAP);
        lap_active_d = (state_d == S_RUN_LAP) || (state_d == S_PAUSE_LAP);
        delay_en_d   = running_d && !(SAT_EN && (time_d == MAX_TIME));
        // The display follows the live time one clock behind, or shows the lap latch.
        digits_d     = lap_active_d ? lap_d : time_q;
        if (sw.clear) begin
            digits_d = '0;
        end
    end

    // State and output registers.
    // An asynchronous reset returns everything to zero or IDLE.
    always_ff @(posedge CLOCK_50 or negedge aclr) begin
        if (!aclr) begin
            state_q      <= S_IDLE;
            time_q       <= '0;
            lap_q        <= '0;
            guard_q      <= '0;
            tick_dly_q   <= 1'b0;
            digits_q     <= '0;
            delay_en_q   <= 1'b0;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            lap_q        <= lap_d;
            guard_q      <= guard_d;
            tick_dly_q   <= sw.tick_q;
            digits_q     <= digits_d;
            delay_en_q   <= delay_en_d;
            running_q    <= running_d;
            lap_active_q <= lap_active_d;
        end
    end

    assign sw.digits     = digits_q;
    assign sw.delay_en   = delay_en_q;
    assign sw.running    = running_q;
    assign sw.lap_active = lap_active_q;

endmodule

// File: tb/tb_stopwatch_10ms_bcd.sv
// Bench for stopwatch_10ms_bcd: directed scenarios plus random control and tick traffic.
// The expected values come from a centisecond-integer reference model.
module tb_stopwatch_10ms_bcd;

    localparam int unsigned MAX_MIN = 1;
    localparam int unsigned GUARD   = 2;
    localparam int          TOTAL   = (MAX_MIN + 1) * 6000;
`ifdef STOPWATCH_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic CLOCK_50 = 1'b0;
    logic aclr;
    logic tq_v;
    int   checks = 0;
    int   errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    stopwatch_10ms_bcd_if sw();

    stopwatch_10ms_bcd #(.MAX_MIN(MAX_MIN), .GUARD(GUARD)) dut (
        .CLOCK_50 (CLOCK_50),
        .aclr     (aclr),
        .sw       (sw)
    );

    // Reference model: time in centiseconds plus a coarse mode description.
    int          m_t, m_lap, m_guard;
    bit          m_idle, m_run, m_lapf, m_prev;
    logic [23:0] e_digits;
    bit          e_run, e_lapa, e_den;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic model_reset();
        m_t = 0; m_lap = 0; m_guard = 0;
        m_idle = 1'b1; m_run = 1'b0; m_lapf = 1'b0; m_prev = 1'b0;
        e_digits = '0; e_run = 1'b0; e_lapa = 1'b0; e_den = 1'b0;
    endtask

    task automatic model_step(input bit clr, input bit ss, input bit lp, input bit tq);
        bit tick, cnt;
        int t_old, t_new;
        tick   = (tq != m_prev);
        m_prev = tq;
        t_old  = m_t;
        cnt    = tick && m_run && (m_guard == 0) && !clr && !(SAT && (m_t == TOTAL - 1));
        t_new  = cnt ? (m_t + 1) % TOTAL : m_t;
        if (m_guard > 0) m_guard--;
        if (clr) begin
            m_idle = 1'b1; m_run = 1'b0; m_lapf = 1'b0;
            t_new = 0; m_lap = 0; m_guard = 0;
        end else if (ss) begin
            if (m_idle) begin
                m_idle = 1'b0; m_run = 1'b1; m_guard = GUARD;
            end else if (m_run) begin
                m_run = 1'b0;
            end else begin
                m_run = 1'b1;
                if (!m_lapf) m_guard = GUARD;
            end
        end else if (lp) begin
            if (m_run) begin
                if (!m_lapf) begin
                    m_lapf = 1'b1;
                    m_lap  = t_old;
                end else begin
                    m_lapf = 1'b0;
                end
            end else if (!m_idle && m_lapf) begin
                m_lapf = 1'b0;
            end
        end
        m_t      = t_new;
        e_digits = clr ? 24'h0 : (m_lapf ? to_bcd(m_lap) : to_bcd(t_old));
        e_run    = m_run;
        e_lapa   = m_lapf;
        e_den    = m_run && !(SAT && (m_t == TOTAL - 1));
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare at the next negedge.
    task automatic step(input bit clr, input bit ss, input bit lp, input bit tog);
        if (tog) tq_v = ~tq_v;
        sw.clear      = clr;
        sw.start_stop = ss;
        sw.lap        = lp;
        sw.tick_q     = tq_v;
        @(posedge CLOCK_50);
        model_step(clr, ss, lp, tq_v);
        @(negedge CLOCK_50);
        check("digits", 32'(sw.digits), 32'(e_digits));
        check("running", 32'(sw.running), 32'(e_run));
        check("lap_active", 32'(sw.lap_active), 32'(e_lapa));
        check("delay_en", 32'(sw.delay_en), 32'(e_den));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        sw.clear = 1'b0; sw.start_stop = 1'b0; sw.lap = 1'b0;
        aclr = 1'b0;
        #1;
        model_reset();
        check("rst_digits", 32'(sw.digits), 32'h0);
        check("rst_running", 32'(sw.running), 32'h0);
        check("rst_lap_active", 32'(sw.lap_active), 32'h0);
        check("rst_delay_en", 32'(sw.delay_en), 32'h0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        aclr = 1'b1;
    endtask

    initial begin
        aclr = 1'b0;
        tq_v = 1'b0;
        sw.tick_q = 1'b0; sw.clear = 1'b0; sw.start_stop = 1'b0; sw.lap = 1'b0;
        @(negedge CLOCK_50);
        do_reset();

        // Edges in IDLE are not counted.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("idle_digits", 32'(sw.digits), 32'h000000);
        check("idle_delay_en", 32'(sw.delay_en), 32'h0);

        // Run 150 ticks spaced 20 cycles apart.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(GUARD + 1);
        for (int i = 0; i < 150; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            idle(19);
        end
        check("run150_digits", 32'(sw.digits), 32'h000150);
        check("run150_running", 32'(sw.running), 32'h1);

        // Lap freeze while 30 more ticks accumulate, then release it.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        idle(2);
        check("lap_hold_digits", 32'(sw.digits), 32'h000150);
        check("lap_hold_active", 32'(sw.lap_active), 32'h1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_release_digits", 32'(sw.digits), 32'h000180);

        // A clear wins over a tick in the same cycle.
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("clear_digits", 32'(sw.digits), 32'h000000);
        check("clear_running", 32'(sw.running), 32'h0);
        check("clear_delay_en", 32'(sw.delay_en), 32'h0);
        idle(3);

        // Run to MAX_MIN:59.99, then send one more tick: it wraps, or it saturates.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(GUARD + 1);
        for (int i = 0; i < TOTAL - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("max_digits", 32'(sw.digits), 32'h015999);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("wrap_digits", 32'(sw.digits), SAT ? 32'h015999 : 32'h000000);
        check("wrap_running", 32'(sw.running), 32'h1);
        check("wrap_delay_en", 32'(sw.delay_en), SAT ? 32'h0 : 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Pause ignores ticks, and so does the guard window after resuming.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(GUARD + 1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        idle(2);
        check("pre_pause_digits", 32'(sw.digits), 32'h000007);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            idle(1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        check("pause_guard_digits", 32'(sw.digits), 32'h000007);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("resume_digits", 32'(sw.digits), 32'h000008);

        // Random control and tick traffic, with one asynchronous reset midway.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_10ms_bcd.md
Name: stopwatch_10ms_bcd

Overview:
- Downstream consumer of the 10 ms delay stage: takes its square-wave output Q, whose every edge marks 10 ms elapsed, and accumulates elapsed time as BCD mm:ss.cc.
- Start/stop, lap-freeze and clear control, for driving six 7-segment digits.
- Drives the upstream stage's enable, so the 10 ms phase only advances while the stopwatch runs.

Parameters:
- MAX_MIN, 59, highest minute value before wrap (or saturation, see Optional Feature); legal range 0..99.
- GUARD, 2, clock cycles after entering RUN during which tick edges are ignored.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- aclr  input  1  asynchronous reset, active-low.
- tick_q  input  1  Q of the 10 ms delay stage; each edge, rising or falling, is one 10 ms tick.
- start_stop  input  1  single-cycle pulse; toggles run/pause.
- lap  input  1  single-cycle pulse; freezes or unfreezes the displayed value while counting continues.
- clear  input  1  single-cycle pulse; zeroes time and returns to IDLE.
- delay_en  output  1  enable for the upstream 10 ms stage; 1 in RUN and RUN_LAP.
- digits  output  24  BCD: [23:20] min tens, [19:16] min units, [15:12] s tens, [11:8] s units, [7:4] cs tens, [3:0] cs units.
- running  output  1  1 in RUN or RUN_LAP.
- lap_active  output  1  1 in RUN_LAP or PAUSE_LAP.

Behaviour:
- Reset (aclr=0, asynchronous):
  - state=IDLE; all time digits 0; lap latch 0.
  - digits=0, delay_en=0, running=0, lap_active=0.
  - Edge register tick_d=0; guard counter=0.
- Edge detect:
  - tick_d registers tick_q every cycle; tick = tick_q XOR tick_d.
  - tick is counted only when state is RUN or RUN_LAP and the guard counter is 0.
- Guard counter:
  - Loaded with GUARD on every transition into RUN from IDLE or PAUSE.
  - Decrements to 0; edges seen while it is nonzero are dropped. This masks upstream Q toggling while its enable was low.
- Time counter:
  - Counted tick increments cs units; carry chain is cs 0..99 -> s 0..59 -> min 0..MAX_MIN.
  - Each BCD nibble stays within 0..9 (tens of seconds 0..5).
  - Update is visible on digits one clock after the cycle where tick=1, i.e. two clocks after tick_q changes.
  - At MAX_MIN:59.99 a tick wraps the time to 00:00.00.
- States and transitions. Priority per cycle: clear > start_stop > lap.
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE; lap -> RUN_LAP, latching the current time.
  - RUN_LAP: start_stop -> PAUSE_LAP; lap -> RUN, display goes live.
  - PAUSE: start_stop -> RUN; lap ignored.
  - PAUSE_LAP: start_stop -> RUN_LAP; lap -> PAUSE, display shows live (paused) time.
  - clear in any state: -> IDLE, time=0, lap latch=0, guard=0. A tick in the same cycle is discarded.
- Display:
  - digits shows the lap latch in RUN_LAP and PAUSE_LAP, otherwise the live time.
  - Registered output, no combinational path from the inputs.
- Counting never occurs in IDLE, PAUSE or PAUSE_LAP, regardless of tick_q activity.
- start_stop and lap pulses held longer than one cycle are each acted on once per cycle asserted. Callers supply single-cycle pulses.
- Reset mid-count returns to the reset state immediately; no partial carry is retained.

Optional Feature:
- Macro STOPWATCH_SATURATE_EN.
- Defined:
  - At MAX_MIN:59.99 further ticks are ignored and the time holds.
  - State stays RUN or RUN_LAP; delay_en is forced to 0 while saturated.
  - clear or reset leaves saturation.
- Undefined: the time wraps to 00:00.00 and counting continues.

Test Plan:
- Reset, then toggle tick_q 5 times with no start_stop -> digits=0x000000, delay_en=0.
- start_stop, wait GUARD+1 cycles, 150 tick_q edges every 20 cycles -> digits=0x000150, i.e. 00:01.50; running=1.
- While running at 00:01.50 pulse lap, then 30 more edges -> digits holds 0x000150 with lap_active=1. Pulse lap again -> digits=0x000180 on the next cycle.
- In RUN, assert clear and a tick_q edge in the same cycle -> next cycle digits=0, state IDLE, delay_en=0.
- Preload 59:59.99 with MAX_MIN=59 via 359999 edges, then 1 more edge:
  - Without the macro -> digits=0x000000 and running=1.
  - With STOPWATCH_SATURATE_EN -> digits=0x595999 and delay_en=0.
- start_stop into PAUSE, toggle tick_q 10 times, start_stop again with a tick_q edge in the first GUARD cycles -> digits unchanged by all of those edges.
